// File: rtl/assay_scheduler.sv
// assay_scheduler: steps N_CH assay channels through LOAD -> MIX -> WAIT_DET -> DETECT -> FLUSH
//   and shares the one fluorescence detector readout between them with round-robin priority.
// Latency: a start taken at edge t opens inlet_valve from t+1; a grant decided in cycle t gives DETECT at t+1.
// Backpressure: start is never stalled (a start to a busy channel is dropped and flagged on start_err);
//   channels wait only in WAIT_DET for the detector, and leave DETECT on det_ack.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start[N_CH]               per-channel start pulse
//   load/mix/flush_cycles     phase durations, captured when a start is accepted (0 behaves as 1)
//   inlet_valve/mix_en/flush_valve[N_CH]  per-channel phase outputs
//   det_req, det_ch, det_ack  shared detector request, owner index, sample-complete pulse
//   busy[N_CH], done[N_CH]    channel not idle, one-cycle completion pulse
//   start_err                 one-cycle pulse, a start hit a busy channel
module assay_scheduler #(
  parameter int N_CH = 9,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] start,
  input  logic [CW-1:0]   load_cycles,
  input  logic [CW-1:0]   mix_cycles,
  input  logic [CW-1:0]   flush_cycles,
  output logic [N_CH-1:0] inlet_valve,
  output logic [N_CH-1:0] mix_en,
  output logic [N_CH-1:0] flush_valve,
  output logic            det_req,
  output logic [3:0]      det_ch,
  input  logic            det_ack,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] done,
  output logic            start_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MIX,
    S_WAIT_DET,
    S_DETECT,
    S_FLUSH
  } state_t;

  localparam logic [3:0] LAST_CH = 4'(N_CH - 1);

  state_t          st        [N_CH];
  state_t          st_nxt    [N_CH];
  logic [CW-1:0]   cnt       [N_CH];
  logic [CW-1:0]   cnt_nxt   [N_CH];
  logic [CW-1:0]   mix_len   [N_CH];
  logic [CW-1:0]   flush_len [N_CH];
  logic [3:0]      rr_ptr;
  logic            det_busy;
  logic            grant_vld;
  logic [3:0]      grant_ch;
  logic [N_CH-1:0] active;

  // Counters run down to zero, so a phase of n cycles starts at n-1; a length of 0 runs one cycle.
  function automatic logic [CW-1:0] last_count(input logic [CW-1:0] n);
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

  // Detector arbitration. A grant moves the winner straight into DETECT at the next edge,
  // so "a channel in DETECT" also covers "a grant is pending" and no separate flag is needed.
  always_comb begin
    det_busy  = 1'b0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (st[i] == S_DETECT) det_busy = 1'b1;
    end
    // Upward search from the pointer with wrap: first the channels at or above it, then below it.
    for (int i = 0; i < N_CH; i++) begin
      if (!grant_vld && !det_busy && st[i] == S_WAIT_DET && 4'(i) >= rr_ptr) begin
        grant_vld = 1'b1;
        grant_ch  = 4'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!grant_vld && !det_busy && st[i] == S_WAIT_DET && 4'(i) < rr_ptr) begin
        grant_vld = 1'b1;
        grant_ch  = 4'(i);
      end
    end
  end

  // Per-channel next state and phase counter.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_nxt[i]  = st[i];
      cnt_nxt[i] = cnt[i];
      active[i]  = (st[i] != S_IDLE);
      case (st[i])
        S_IDLE: begin
          if (start[i]) begin
            st_nxt[i]  = S_LOAD;
            cnt_nxt[i] = last_count(load_cycles);
          end
        end
        S_LOAD: begin
          if (cnt[i] == '0) begin
            st_nxt[i]  = S_MIX;
            cnt_nxt[i] = last_count(mix_len[i]);
          end else begin
            cnt_nxt[i] = cnt[i] - 1'b1;
          end
        end
        S_MIX: begin
          if (cnt[i] == '0) begin
            st_nxt[i] = S_WAIT_DET;
          end else begin
            cnt_nxt[i] = cnt[i] - 1'b1;
          end
        end
        S_WAIT_DET: begin
          if (grant_vld && grant_ch == 4'(i)) st_nxt[i] = S_DETECT;
        end
        S_DETECT: begin
          if (det_ack) begin
            st_nxt[i]  = S_FLUSH;
            cnt_nxt[i] = last_count(flush_len[i]);
          end
        end
        S_FLUSH: begin
          if (cnt[i] == '0) begin
            st_nxt[i] = S_IDLE;
          end else begin
            cnt_nxt[i] = cnt[i] - 1'b1;
          end
        end
        default: begin
          st_nxt[i] = S_IDLE;
        end
      endcase
    end
  end

  // State, captured durations and all outputs. Outputs are decoded from the next state and
  // registered alongside it, so each one is a clean flop that tracks the state it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        st[i]        <= S_IDLE;
        cnt[i]       <= '0;
        mix_len[i]   <= '0;
        flush_len[i] <= '0;
      end
      rr_ptr      <= '0;
      inlet_valve <= '0;
      mix_en      <= '0;
      flush_valve <= '0;
      busy        <= '0;
      done        <= '0;
      det_req     <= 1'b0;
      det_ch      <= '0;
      start_err   <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st[i]  <= st_nxt[i];
        cnt[i] <= cnt_nxt[i];
        // The LOAD length goes straight into the counter; MIX and FLUSH lengths are held
        // here so later changes on the configuration inputs cannot reach a running channel.
        if (st[i] == S_IDLE && start[i]) begin
          mix_len[i]   <= mix_cycles;
          flush_len[i] <= flush_cycles;
        end
        inlet_valve[i] <= (st_nxt[i] == S_LOAD);
        mix_en[i]      <= (st_nxt[i] == S_MIX);
        flush_valve[i] <= (st_nxt[i] == S_FLUSH);
        busy[i]        <= (st_nxt[i] != S_IDLE);
        done[i]        <= (st[i] == S_FLUSH) && (st_nxt[i] == S_IDLE);
      end
      // Next cycle has an owner if a grant is issued now or the current owner is not acked.
      det_req <= grant_vld || (det_busy && !det_ack);
      // det_ch follows only grants, so it keeps the last owner while the detector is idle.
      if (grant_vld) begin
        det_ch <= grant_ch;
        rr_ptr <= (grant_ch == LAST_CH) ? 4'd0 : grant_ch + 4'd1;
      end
      start_err <= |(start & active);
    end
  end

endmodule

// File: tb/tb_assay_scheduler.sv
// tb_assay_scheduler: randomized and directed stimulus for assay_scheduler against a phase/remaining-time
//   model of each channel plus a round-robin detector arbiter; outputs sampled 1 ns after each rising edge.
// Ports: none (top-level bench).
module tb_assay_scheduler;

  localparam int N_CH = 9;
  localparam int CW   = 8;

  // Model phase codes
  localparam int P_IDLE = 0, P_LOAD = 1, P_MIX = 2, P_WAIT = 3, P_DET = 4, P_FLUSH = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] start = '0;
  logic [CW-1:0]   load_cycles = '0;
  logic [CW-1:0]   mix_cycles = '0;
  logic [CW-1:0]   flush_cycles = '0;
  logic [N_CH-1:0] inlet_valve;
  logic [N_CH-1:0] mix_en;
  logic [N_CH-1:0] flush_valve;
  logic            det_req;
  logic [3:0]      det_ch;
  logic            det_ack = 1'b0;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] done;
  logic            start_err;

  always #5 clk = ~clk;

  assay_scheduler #(.N_CH(N_CH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_cycles(load_cycles), .mix_cycles(mix_cycles), .flush_cycles(flush_cycles),
    .inlet_valve(inlet_valve), .mix_en(mix_en), .flush_valve(flush_valve),
    .det_req(det_req), .det_ch(det_ch), .det_ack(det_ack),
    .busy(busy), .done(done), .start_err(start_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_ph   [N_CH];
  int              m_left [N_CH];
  int              m_mixv [N_CH];
  int              m_flv  [N_CH];
  int              m_age  [N_CH];
  int              m_ptr;
  int              m_detch;
  logic [N_CH-1:0] m_done;
  logic            m_err;

  function automatic int len_of(input logic [CW-1:0] n);
    return (n == 0) ? 1 : int'(n);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_ph[c] = P_IDLE; m_left[c] = 0; m_mixv[c] = 1; m_flv[c] = 1; m_age[c] = 0;
    end
    m_ptr = 0; m_detch = 0; m_done = '0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    int g;
    bit owner;
    if (rst) begin
      model_reset();
      return;
    end
    owner = 0;
    for (int c = 0; c < N_CH; c++) if (m_ph[c] == P_DET) owner = 1;
    g = -1;
    if (!owner) begin
      for (int off = 0; off < N_CH; off++) begin
        int c;
        c = (m_ptr + off) % N_CH;
        if (g < 0 && m_ph[c] == P_WAIT) g = c;
      end
    end
    m_err  = 1'b0;
    m_done = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (start[c] && m_ph[c] != P_IDLE) m_err = 1'b1;
      case (m_ph[c])
        P_IDLE: if (start[c]) begin
          m_ph[c] = P_LOAD; m_left[c] = len_of(load_cycles);
          m_mixv[c] = len_of(mix_cycles); m_flv[c] = len_of(flush_cycles);
        end
        P_LOAD: begin
          m_left[c]--;
          if (m_left[c] == 0) begin m_ph[c] = P_MIX; m_left[c] = m_mixv[c]; end
        end
        P_MIX: begin
          m_left[c]--;
          if (m_left[c] == 0) m_ph[c] = P_WAIT;
        end
        P_WAIT: if (c == g) begin m_ph[c] = P_DET; m_age[c] = 1; end
        P_DET: begin
          if (det_ack) begin m_ph[c] = P_FLUSH; m_left[c] = m_flv[c]; end
          else m_age[c]++;
        end
        P_FLUSH: begin
          m_left[c]--;
          if (m_left[c] == 0) begin m_ph[c] = P_IDLE; m_done[c] = 1'b1; end
        end
        default: m_ph[c] = P_IDLE;
      endcase
    end
    if (g >= 0) begin
      m_ptr   = (g + 1) % N_CH;
      m_detch = g;
    end
  endtask

  task automatic check_all();
    logic [N_CH-1:0] e_in, e_mx, e_fl, e_bz;
    logic            e_req;
    e_in = '0; e_mx = '0; e_fl = '0; e_bz = '0; e_req = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      e_in[c] = (m_ph[c] == P_LOAD);
      e_mx[c] = (m_ph[c] == P_MIX);
      e_fl[c] = (m_ph[c] == P_FLUSH);
      e_bz[c] = (m_ph[c] != P_IDLE);
      if (m_ph[c] == P_DET) e_req = 1'b1;
    end
    check("inlet_valve", 32'(inlet_valve), 32'(e_in));
    check("mix_en",      32'(mix_en),      32'(e_mx));
    check("flush_valve", 32'(flush_valve), 32'(e_fl));
    check("busy",        32'(busy),        32'(e_bz));
    check("done",        32'(done),        32'(m_done));
    check("det_req",     32'(det_req),     32'(e_req));
    check("det_ch",      32'(det_ch),      32'(m_detch));
    check("start_err",   32'(start_err),   32'(m_err));
  endtask

  // ---------------- observation log ----------------
  int   owners [$];
  int   gaps   [$];
  bit   had_owner;
  bit   prev_req;
  int   low_run;
  int   cnt_in [N_CH];
  int   cnt_mx [N_CH];
  int   cnt_fl [N_CH];
  int   ack_delay = -1;

  task automatic clear_log();
    owners.delete(); gaps.delete();
    had_owner = 0; prev_req = 0; low_run = 0;
    for (int c = 0; c < N_CH; c++) begin cnt_in[c] = 0; cnt_mx[c] = 0; cnt_fl[c] = 0; end
  endtask

  task automatic track();
    if (det_req && !prev_req) begin
      owners.push_back(int'(det_ch));
      if (had_owner) gaps.push_back(low_run);
      had_owner = 1;
    end
    if (det_req) low_run = 0; else low_run++;
    prev_req = det_req;
    for (int c = 0; c < N_CH; c++) begin
      if (inlet_valve[c]) cnt_in[c]++;
      if (mix_en[c])      cnt_mx[c]++;
      if (flush_valve[c]) cnt_fl[c]++;
    end
  endtask

  // One clock: DUT and model both consume the inputs present at the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    track();
    start   = '0;
    det_ack = 1'b0;
    if (ack_delay >= 0) begin
      for (int c = 0; c < N_CH; c++)
        if (m_ph[c] == P_DET && m_age[c] == ack_delay + 1) det_ack = 1'b1;
    end
  endtask

  task automatic do_reset();
    start = '0; det_ack = 1'b0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic set_cfg(input int l, input int m, input int f);
    load_cycles = CW'(l); mix_cycles = CW'(m); flush_cycles = CW'(f);
  endtask

  task automatic check_owners(input string tag, input int n, input int e [3]);
    check({tag, "_count"}, 32'(owners.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check($sformatf("%s_owner%0d", tag, i), (i < owners.size()) ? 32'(owners[i]) : 32'hFFFF, 32'(e[i]));
  endtask

  initial begin
    model_reset();
    clear_log();

    // Reset state and single-channel timeline
    do_reset();
    clear_log();
    set_cfg(3, 4, 2);
    ack_delay = 3;
    start[0] = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      step();
      if (t == 2) set_cfg(9, 11, 13);  // must not disturb the running channel
      check($sformatf("t1_inlet_c%0d", t), 32'(inlet_valve[0]), 32'(t >= 1 && t <= 3));
      check($sformatf("t1_mix_c%0d", t),   32'(mix_en[0]),      32'(t >= 4 && t <= 7));
      check($sformatf("t1_req_c%0d", t),   32'(det_req),        32'(t >= 9 && t <= 12));
      check($sformatf("t1_flush_c%0d", t), 32'(flush_valve[0]), 32'(t >= 13 && t <= 14));
      check($sformatf("t1_done_c%0d", t),  32'(done[0]),        32'(t == 15));
      check($sformatf("t1_busy_c%0d", t),  32'(busy[0]),        32'(t >= 1 && t <= 14));
      check($sformatf("t1_ch_c%0d", t),    32'(det_ch),         32'd0);
    end

    // Zero durations on channel 2
    do_reset();
    clear_log();
    set_cfg(0, 0, 0);
    ack_delay = 1;
    start[2] = 1'b1;
    for (int t = 0; t < 12; t++) step();
    check("zero_load_len",  32'(cnt_in[2]), 32'd1);
    check("zero_mix_len",   32'(cnt_mx[2]), 32'd1);
    check("zero_flush_len", 32'(cnt_fl[2]), 32'd1);
    check_owners("zero", 1, '{2, 0, 0});

    // Arbitration of three simultaneous channels
    do_reset();
    clear_log();
    set_cfg(2, 2, 1);
    ack_delay = 2;
    start = N_CH'((1 << 0) | (1 << 3) | (1 << 8));
    for (int t = 0; t < 40; t++) step();
    check_owners("arb", 3, '{0, 3, 8});
    check("arb_gap_count", 32'(gaps.size()), 32'd2);
    foreach (gaps[i]) check($sformatf("arb_gap%0d", i), 32'(gaps[i]), 32'd1);

    // Round-robin fairness: 3 served first, then 5 before 1
    do_reset();
    clear_log();
    set_cfg(1, 1, 1);
    ack_delay = 3;
    start[3] = 1'b1;
    step();
    start[1] = 1'b1;
    start[5] = 1'b1;
    step();
    for (int t = 0; t < 40; t++) step();
    check_owners("rr", 3, '{3, 5, 1});

    // Restart during MIX and a stray det_ack
    do_reset();
    clear_log();
    set_cfg(2, 5, 2);
    ack_delay = 2;
    start[4] = 1'b1;
    step();           // cycle 1, LOAD
    det_ack = 1'b1;   // detector idle: must be ignored
    step();           // cycle 2
    step();           // cycle 3, MIX
    start[4] = 1'b1;
    step();           // cycle 4
    check("err_pulse", 32'(start_err), 32'd1);
    for (int t = 0; t < 25; t++) step();
    check("err_load_len",  32'(cnt_in[4]), 32'd2);
    check("err_mix_len",   32'(cnt_mx[4]), 32'd5);
    check("err_flush_len", 32'(cnt_fl[4]), 32'd2);
    check_owners("err", 1, '{4, 0, 0});

    // Mid-operation reset: ch1 in DETECT, ch6 in LOAD
    do_reset();
    clear_log();
    set_cfg(1, 1, 1);
    ack_delay = -1;
    start[1] = 1'b1;
    step();           // cycle 1
    set_cfg(20, 1, 1);
    start[6] = 1'b1;
    step();           // cycle 2
    step(); step(); step();  // cycle 5
    #2 rst = 1'b1;
    #1;
    check("arst_inlet", 32'(inlet_valve), 32'd0);
    check("arst_mix",   32'(mix_en),      32'd0);
    check("arst_flush", 32'(flush_valve), 32'd0);
    check("arst_busy",  32'(busy),        32'd0);
    check("arst_req",   32'(det_req),     32'd0);
    check("arst_ch",    32'(det_ch),      32'd0);
    model_reset();
    check_all();
    step(); step();
    rst = 1'b0;
    clear_log();
    set_cfg(2, 2, 2);
    ack_delay = 2;
    start[6] = 1'b1;
    start[0] = 1'b1;
    for (int t = 0; t < 30; t++) step();
    check_owners("post_rst", 2, '{0, 6, 0});
    check("post_rst_flush6", 32'(cnt_fl[6]), 32'd2);

    // Randomized traffic with random acks (including stray ones)
    do_reset();
    clear_log();
    ack_delay = -1;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N_CH; c++) start[c] = ($urandom_range(0, 11) == 0);
      set_cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      det_ack = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
